// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the result from MEM/WB, commits it to the integer register file,
// serves the decode read ports with write-through bypass and counts retired instructions.
module wb_regfile_stage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ResultSrcW,
  input  logic              RegWriteW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUResultW,
  input  logic [ADDR_W-1:0] RdW,
  input  logic [DATA_W-1:0] ExtImmW,
  input  logic [DATA_W-1:0] PCPlus4W,
  input  logic              ValidW,
  input  logic [ADDR_W-1:0] Rs1D,
  input  logic [ADDR_W-1:0] Rs2D,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] ResultW,
  output logic [CNT_W-1:0]  InstRetCount
);

  logic [DATA_W-1:0] result_w;
  logic              wr_en;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              byp1;
  logic              byp2;

  always_comb begin
    result_w = ALUResultW;
    case (ResultSrcW)
      2'b00:   result_w = ALUResultW;
      2'b01:   result_w = ReadDataW;
      2'b10:   result_w = PCPlus4W;
      2'b11:   result_w = ExtImmW;
      default: result_w = ALUResultW;
    endcase
  end

  assign ResultW = result_w;

  // x0 is never written, so it stays zero after reset.
  assign wr_en = rst && RegWriteW && (RdW != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RdW] = result_w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ValidW) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign InstRetCount = cnt_q;

  // Same-cycle write-through replaces the classic negedge register-file write.
  assign byp1 = wr_en && (RdW == Rs1D);
  assign byp2 = wr_en && (RdW == Rs2D);

  always_comb begin
    RD1D = '0;
    if (rst && (Rs1D != '0)) begin
      RD1D = byp1 ? result_w : regs_q[Rs1D];
    end
  end

  always_comb begin
    RD2D = '0;
    if (rst && (Rs2D != '0)) begin
      RD2D = byp2 ? result_w : regs_q[Rs2D];
    end
  end

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: a reference model predicts every output each cycle,
// plus a narrow-counter instance to exercise the wrap boundary.
module tb_wb_regfile_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  src;
  logic        we;
  logic [31:0] rdata, alu, imm, pc4;
  logic [4:0]  rd, rs1, rs2;
  logic        valid;
  logic [31:0] rd1, rd2, res;
  logic [63:0] cnt;
  logic [31:0] rd1_c4, rd2_c4, res_c4;
  logic [3:0]  cnt_c4;

  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;
  logic [63:0] exp_q [$];
  string       tag_q [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst), .ResultSrcW(src), .RegWriteW(we), .ReadDataW(rdata),
    .ALUResultW(alu), .RdW(rd), .ExtImmW(imm), .PCPlus4W(pc4), .ValidW(valid),
    .Rs1D(rs1), .Rs2D(rs2), .RD1D(rd1), .RD2D(rd2), .ResultW(res), .InstRetCount(cnt)
  );

  wb_regfile_stage #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .ResultSrcW(src), .RegWriteW(we), .ReadDataW(rdata),
    .ALUResultW(alu), .RdW(rd), .ExtImmW(imm), .PCPlus4W(pc4), .ValidW(valid),
    .Rs1D(rs1), .Rs2D(rs2), .RD1D(rd1_c4), .RD2D(rd2_c4), .ResultW(res_c4),
    .InstRetCount(cnt_c4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input string tag);
    case (tag)
      "ResultW": return {32'h0, res};
      "RD1D":    return {32'h0, rd1};
      "RD2D":    return {32'h0, rd2};
      "Count":   return cnt;
      "Count4":  return {60'h0, cnt_c4};
      default:   return 64'hx;
    endcase
  endfunction

  function automatic logic [31:0] m_result();
    case (src)
      2'b00:   return alu;
      2'b01:   return rdata;
      2'b10:   return pc4;
      default: return imm;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (!rst || rs == 5'd0) return 32'h0;
    if (we && rd != 5'd0 && rd == rs) return m_result();
    return m_regs[rs];
  endfunction

  task automatic push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic apply(input logic r, input logic [1:0] s, input logic w, input logic [4:0] d,
                       input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] alu_v, input logic [31:0] rdat_v,
                       input logic [31:0] pc4_v, input logic [31:0] imm_v);
    logic [31:0] r_exp;
    @(negedge clk);
    rst = r; src = s; we = w; rd = d; valid = v; rs1 = a1; rs2 = a2;
    alu = alu_v; rdata = rdat_v; pc4 = pc4_v; imm = imm_v;
    #1;
    r_exp = m_result();
    push("ResultW", {32'h0, r_exp});
    push("RD1D", {32'h0, m_read(a1)});
    push("RD2D", {32'h0, m_read(a2)});
    push("Count", m_cnt);
    push("Count4", {60'h0, m_cnt[3:0]});
    while (tag_q.size() > 0) begin
      string t;
      logic [63:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, observe(t), e);
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 64'h0;
    end else begin
      if (w && d != 5'd0) m_regs[d] = r_exp;
      if (v) m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic idle(input logic r, input logic v, input logic [4:0] a1, input logic [4:0] a2);
    apply(r, 2'b00, 1'b0, 5'd0, v, a1, a2, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b0; src = 2'b00; we = 1'b0; rd = 5'd0; valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0;
    alu = 32'h0; rdata = 32'h0; pc4 = 32'h0; imm = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 64'h0;
    repeat (2) @(posedge clk);

    // reset wipes a previously written register
    apply(1'b1, 2'b00, 1'b1, 5'd5, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 0, 0, 0);
    idle(1'b1, 1'b0, 5'd5, 5'd5);
    chk("x5_written", {32'h0, rd1}, 64'hDEADBEEF);
    idle(1'b0, 1'b0, 5'd5, 5'd0);
    idle(1'b0, 1'b0, 5'd5, 5'd0);
    idle(1'b1, 1'b0, 5'd5, 5'd0);
    #1;
    chk("rst_x5", {32'h0, rd1}, 64'h0);
    chk("rst_cnt", cnt, 64'h0);

    // each mux leg lands in its own register
    apply(1'b1, 2'b01, 1'b1, 5'd7,  1'b1, 5'd0, 5'd0, 32'h11111111, 32'h12345678, 32'h22222222, 32'h33333333);
    apply(1'b1, 2'b00, 1'b1, 5'd8,  1'b1, 5'd7, 5'd0, 32'hCAFE0001, 32'h44444444, 32'h55555555, 32'h66666666);
    apply(1'b1, 2'b10, 1'b1, 5'd10, 1'b1, 5'd8, 5'd0, 32'h77777777, 32'h88888888, 32'h00001004, 32'h99999999);
    apply(1'b1, 2'b11, 1'b1, 5'd11, 1'b1, 5'd10, 5'd0, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hABCDE000);
    idle(1'b1, 1'b0, 5'd11, 5'd7);
    #1;
    chk("mux_01", {32'h0, rd2}, 64'h12345678);
    chk("mux_11", {32'h0, rd1}, 64'hABCDE000);

    // x0 stays zero during and after a write attempt
    apply(1'b1, 2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
    chk("x0_during", {32'h0, rd1}, 64'h0);
    idle(1'b1, 1'b0, 5'd0, 5'd0);
    chk("x0_after", {32'h0, rd1}, 64'h0);

    // bypass on both ports, then no bypass without RegWriteW
    apply(1'b1, 2'b00, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 32'h01020304, 0, 0, 0);
    apply(1'b1, 2'b00, 1'b0, 5'd3, 1'b0, 5'd3, 5'd3, 32'hA5A5A5A5, 0, 0, 0);
    chk("nobyp_old", {32'h0, rd1}, 64'h01020304);
    apply(1'b1, 2'b00, 1'b1, 5'd3, 1'b0, 5'd3, 5'd3, 32'hA5A5A5A5, 0, 0, 0);
    #1;
    chk("x3_committed", {32'h0, rd2}, 64'hA5A5A5A5);

    // retire counting with a 1,1,0,1 ValidW pattern
    idle(1'b0, 1'b0, 5'd0, 5'd0);
    idle(1'b1, 1'b1, 5'd0, 5'd0);
    apply(1'b1, 2'b00, 1'b1, 5'd4, 1'b1, 5'd0, 5'd0, 32'h5, 0, 0, 0);
    idle(1'b1, 1'b0, 5'd0, 5'd0);
    idle(1'b1, 1'b1, 5'd0, 5'd0);
    #1;
    chk("cnt_pattern", cnt, 64'd3);

    // counter wrap on the narrow instance
    idle(1'b0, 1'b0, 5'd0, 5'd0);
    repeat (15) idle(1'b1, 1'b1, 5'd0, 5'd0);
    #1;
    chk("cnt4_max", {60'h0, cnt_c4}, 64'd15);
    idle(1'b1, 1'b1, 5'd0, 5'd0);
    #1;
    chk("cnt4_wrap", {60'h0, cnt_c4}, 64'd0);

    // reset beats a simultaneous write and retire
    apply(1'b1, 2'b00, 1'b1, 5'd9, 1'b1, 5'd0, 5'd0, 32'h0BADF00D, 0, 0, 0);
    apply(1'b0, 2'b00, 1'b1, 5'd9, 1'b1, 5'd9, 5'd9, 32'h12121212, 0, 0, 0);
    chk("rst_nobyp", {32'h0, rd1}, 64'h0);
    idle(1'b1, 1'b0, 5'd9, 5'd0);
    chk("rst_pri_reg", {32'h0, rd1}, 64'h0);
    chk("rst_pri_cnt", cnt, 64'h0);

    // randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      apply(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
